// File: rtl/companion_anim_sequencer_pkg.sv
// Shared companion encodings: animation ids, action codes and sequencer states.
// Also used by companion_fsm, companion_status and the graphics block.
package companion_anim_sequencer_pkg;

    typedef enum logic [2:0] {
        ANIM_IDLE  = 3'd0,
        ANIM_SICK  = 3'd1,
        ANIM_FEED  = 3'd2,
        ANIM_PLAY  = 3'd3,
        ANIM_CLEAN = 3'd4
    } anim_e;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_FEED  = 2'b01,
        ACT_PLAY  = 2'b10,
        ACT_CLEAN = 2'b11
    } action_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_DONE
    } seq_state_e;

    function automatic anim_e action_anim(input action_e act);
        case (act)
            ACT_FEED:  return ANIM_FEED;
            ACT_PLAY:  return ANIM_PLAY;
            ACT_CLEAN: return ANIM_CLEAN;
            default:   return ANIM_IDLE;
        endcase
    endfunction

    // Unsigned 32-bit compare: a huge health value must never read as sick.
    function automatic anim_e idle_anim(input logic [31:0] health_val, input int unsigned threshold);
        return (health_val < threshold) ? ANIM_SICK : ANIM_IDLE;
    endfunction

endpackage

// File: rtl/companion_anim_sequencer_if.sv
// Request/status bundle between the companion FSM (master) and the animation sequencer (slave).
interface companion_anim_sequencer_if;

    logic        exec;
    logic [1:0]  selected;
    logic [31:0] health;
    logic        exec_status;
    logic [2:0]  anim_id;
    logic [3:0]  frame;
    logic        busy;
    logic        frame_tick;

    modport master (
        output exec, selected, health,
        input  exec_status, anim_id, frame, busy, frame_tick
    );

    modport slave (
        input  exec, selected, health,
        output exec_status, anim_id, frame, busy, frame_tick
    );

endinterface

// File: rtl/frame_ticker.sv
// Frame-rate divider: counts 0..CLOCK_FREQ/FRAME_RATE-1 and pulses tick_o on the last count.
module frame_ticker #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned FRAME_RATE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned TICK_MAX = CLOCK_FREQ / FRAME_RATE - 1;
    localparam int unsigned CNT_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign tick_o = (count_q == CNT_W'(TICK_MAX));

    // NOTE: next-state gets a default on the first line so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || tick_o) begin
            count_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/companion_anim_sequencer.sv
// Companion animation sequencer: idle/sick loop, one-shot action animations, and a
// single-cycle completion pulse back to the companion FSM.
module companion_anim_sequencer
    import companion_anim_sequencer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 125_000_000,
    parameter int unsigned FRAME_RATE     = 8,
    parameter int unsigned ACTION_FRAMES  = 8,
    parameter int unsigned IDLE_FRAMES    = 4,
    parameter int unsigned SICK_THRESHOLD = 25
) (
    input logic                       clk,
    input logic                       rst,
    companion_anim_sequencer_if.slave bus
);

    seq_state_e state_q, state_d;
    anim_e      anim_q, anim_d;
    logic [3:0] frame_q, frame_d;
    logic       tick;
    logic       clear;
    anim_e      rest_anim;
    action_e    req_act;

    assign rest_anim = idle_anim(bus.health, SICK_THRESHOLD);
    assign req_act   = action_e'(bus.selected);

    frame_ticker #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .FRAME_RATE (FRAME_RATE)
    ) u_ticker (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .tick_o  (tick)
    );

    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        frame_d = frame_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                anim_d = rest_anim;
                if (bus.exec) begin
                    clear   = 1'b1;
                    frame_d = '0;
                    if (req_act == ACT_NONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PLAY;
                        anim_d  = action_anim(req_act);
                    end
                end else if (rest_anim != anim_q) begin
                    // Switching between idle and sick loops restarts the loop from frame 0.
                    clear   = 1'b1;
                    frame_d = '0;
                end else if (tick) begin
                    frame_d = (frame_q == 4'(IDLE_FRAMES - 1)) ? 4'd0 : frame_q + 4'd1;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (frame_q == 4'(ACTION_FRAMES - 1)) begin
                        state_d = ST_DONE;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                anim_d  = rest_anim;
                frame_d = '0;
                clear   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                anim_d  = rest_anim;
                frame_d = '0;
                clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            anim_q  <= rest_anim;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            frame_q <= frame_d;
        end
    end

    assign bus.busy        = (state_q == ST_PLAY);
    assign bus.exec_status = (state_q == ST_DONE);
    assign bus.anim_id     = anim_q;
    assign bus.frame       = frame_q;
    assign bus.frame_tick  = tick;

endmodule
